// File: rtl/add16_pkg.sv
// add16_pkg: shared types for the add16 execute stage
package add16_pkg;
  localparam int W = 16;
  typedef enum logic [1:0] {OP_ADD, OP_ADC, OP_SUB, OP_SBC} op_e;
  typedef struct packed {
    logic [W-1:0] sum;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } res_t;
endpackage

// File: rtl/adder_16b.sv
// adder_16b: 16-bit ripple-carry adder with bit-array ports
module adder_16b (
  input  logic a [15:0],
  input  logic b [15:0],
  input  logic cin,
  output logic sum [15:0],
  output logic cout
);
  logic c [16:0];
  assign c[0] = cin;
  genvar i;
  generate
    for (i = 0; i < 16; i++) begin : g_bit
      assign sum[i]  = a[i] ^ b[i] ^ c[i];
      assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  endgenerate
  assign cout = c[16];
endmodule

// File: rtl/sync_fifo_res.sv
// sync_fifo_res: small result FIFO with separate occupancy counter
module sync_fifo_res import add16_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  res_t din,
  output res_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  res_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push_ok, pop_ok;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];
  // storage, wrapping pointers and occupancy; reset discards all entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/add16_flag_stage.sv
// add16_flag_stage: registered ADD/ADC/SUB/SBC stage with flags, accumulator and output FIFO
module add16_flag_stage import add16_pkg::*; #(
  parameter int WIDTH     = 16,
  parameter int OUT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_use_acc,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             clr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n,
  output logic [WIDTH-1:0] acc_q
);
  op_e          op;
  logic         c_q, cin, cout, full, empty, accept, pop;
  logic [W-1:0] a_op, b_op, sum;
  logic         a_bits [W-1:0];
  logic         b_bits [W-1:0];
  logic         s_bits [W-1:0];
  res_t         res, head;
  assign op     = op_e'(in_op);
  assign a_op   = in_use_acc ? acc_q : in_a;
  assign b_op   = op[1] ? ~in_b : in_b;
  assign cin    = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : c_q;
  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_bridge
      assign a_bits[i] = a_op[i];
      assign b_bits[i] = b_op[i];
      assign sum[i]    = s_bits[i];
    end
  endgenerate
  adder_16b u_add (
    .a   (a_bits),
    .b   (b_bits),
    .cin (cin),
    .sum (s_bits),
    .cout(cout)
  );
  assign res = {sum, cout,
                (a_op[W-1] == b_op[W-1]) && (sum[W-1] != a_op[W-1]),
                sum == '0, sum[W-1]};
  sync_fifo_res #(.DEPTH(OUT_DEPTH)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (accept),
    .pop  (pop),
    .din  (res),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_sum   = head.sum;
  assign out_c     = head.c;
  assign out_v     = head.v;
  assign out_z     = head.z;
  assign out_n     = head.n;
  // accumulator and carry follow each accepted result; clear wins over update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      c_q   <= 1'b0;
    end else if (clr_acc) begin
      acc_q <= '0;
      c_q   <= 1'b0;
    end else if (accept) begin
      acc_q <= sum;
      c_q   <= cout;
    end
  end
endmodule

// File: tb/tb_add16_flag_stage.sv
// tb_add16_flag_stage: directed and randomized checks against an arithmetic reference model
module tb_add16_flag_stage;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_use_acc = 0, clr_acc = 0, out_ready = 0;
  logic [1:0]  in_op = 0;
  logic [15:0] in_a = 0, in_b = 0;
  logic        in_ready, out_valid, out_c, out_v, out_z, out_n;
  logic [15:0] out_sum, acc_q;
  int          vectors = 0, miscompares = 0;
  logic [15:0] m_acc = 0;
  logic        m_c = 0;
  logic [19:0] q [$];

  add16_flag_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_use_acc(in_use_acc), .in_a(in_a), .in_b(in_b),
    .clr_acc(clr_acc), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_c(out_c), .out_v(out_v), .out_z(out_z),
    .out_n(out_n), .acc_q(acc_q)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic cq);
    int ua, ub, sa, sb, ur, sr, k;
    logic [15:0] s;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    k  = op[1] ? ((op[0] && !cq) ? 1 : 0) : ((op[0] && cq) ? 1 : 0);
    ur = op[1] ? ua - ub - k : ua + ub + k;
    sr = op[1] ? sa - sb - k : sa + sb + k;
    c  = op[1] ? (ur >= 0) : (ur > 65535);
    s  = 16'(ur);
    v  = (sr > 32767) || (sr < -32768);
    return {s, c, v, s == 16'h0, s[15]};
  endfunction

  task automatic apply(input logic [1:0] op, input logic use_acc, input logic [15:0] a, input logic [15:0] b, input logic clr);
    logic [19:0] e;
    int n;
    n = 0;
    in_op = op; in_use_acc = use_acc; in_a = a; in_b = b; clr_acc = clr; in_valid = 1;
    while (!in_ready && n < 20) begin
      tick;
      n++;
    end
    vectors++;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL apply_ready_timeout: in_ready=%0b required 1", in_ready);
    end
    e = model(op, use_acc ? m_acc : a, b, m_c);
    m_acc = clr ? 16'h0 : e[19:4];
    m_c   = clr ? 1'b0 : e[3];
    tick;
    in_valid = 0;
    clr_acc  = 0;
  endtask

  task automatic test_reset;
    vectors++;
    if ({out_valid, in_ready, acc_q, out_sum, out_c, out_v, out_z, out_n} !== {1'b0, 1'b1, 16'h0, 16'h0, 4'h0}) begin
      miscompares++;
      $display("FAIL reset: valid=%0b ready=%0b acc=%h sum=%h flags=%b%b%b%b required 0 1 0000 0000 0000",
               out_valid, in_ready, acc_q, out_sum, out_c, out_v, out_z, out_n);
    end
  endtask

  task automatic test_flags;
    logic [1:0]  op  [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [15:0] a   [5] = '{16'h7FFF, 16'hFFFF, 16'h0000, 16'h0003, 16'h0010};
    logic [15:0] b   [5] = '{16'h0001, 16'h0001, 16'h0000, 16'h0005, 16'h0001};
    logic [19:0] exp [5] = '{{16'h8000, 4'b0101}, {16'h0000, 4'b1010}, {16'h0001, 4'b0000},
                             {16'hFFFE, 4'b0001}, {16'h000E, 4'b1000}};
    out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      apply(op[k], 1'b0, a[k], b[k], 1'b0);
      vectors++;
      if ({out_valid, out_sum, out_c, out_v, out_z, out_n} !== {1'b1, exp[k]}) begin
        miscompares++;
        $display("FAIL flags_%0d: valid=%0b sum=%h cvzn=%b%b%b%b required 1 %h %b",
                 k, out_valid, out_sum, out_c, out_v, out_z, out_n, exp[k][19:4], exp[k][3:0]);
      end
      vectors++;
      if (acc_q !== exp[k][19:4]) begin
        miscompares++;
        $display("FAIL flags_acc_%0d: acc=%h required %h", k, acc_q, exp[k][19:4]);
      end
    end
    tick;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flags_drain: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 0; in_use_acc = 0; in_op = 2'd0; clr_acc = 0;
    in_valid = 1; in_a = 1; in_b = 1;
    tick;
    in_a = 2; in_b = 2;
    tick;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_full: in_ready=%0b required 0", in_ready);
    end
    in_a = 3; in_b = 3;
    tick;
    vectors++;
    if ({in_ready, out_valid, out_sum} !== {1'b0, 1'b1, 16'd2}) begin
      miscompares++;
      $display("FAIL b2b_hold: ready=%0b valid=%0b sum=%h required 0 1 0002", in_ready, out_valid, out_sum);
    end
    out_ready = 1;
    tick;
    vectors++;
    if ({in_ready, out_valid, out_sum} !== {1'b1, 1'b1, 16'd4}) begin
      miscompares++;
      $display("FAIL b2b_pop1: ready=%0b valid=%0b sum=%h required 1 1 0004", in_ready, out_valid, out_sum);
    end
    tick;
    in_valid = 0;
    vectors++;
    if ({out_valid, out_sum, acc_q} !== {1'b1, 16'd6, 16'd6}) begin
      miscompares++;
      $display("FAIL b2b_third: valid=%0b sum=%h acc=%h required 1 0006 0006", out_valid, out_sum, acc_q);
    end
    tick;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_empty: out_valid=%0b required 0", out_valid);
    end
    m_acc = 16'd6;
    m_c   = 1'b0;
  endtask

  task automatic test_accumulate;
    clr_acc = 1; in_valid = 0;
    tick;
    clr_acc = 0;
    vectors++;
    if (acc_q !== 16'h0) begin
      miscompares++;
      $display("FAIL acc_clear: acc=%h required 0000", acc_q);
    end
    out_ready = 1; in_use_acc = 1; in_op = 2'd0; in_a = 16'hDEAD; in_b = 16'd5; in_valid = 1;
    for (int k = 1; k <= 4; k++) begin
      tick;
      vectors++;
      if ({out_valid, out_sum, acc_q} !== {1'b1, 16'(5 * k), 16'(5 * k)}) begin
        miscompares++;
        $display("FAIL acc_step_%0d: valid=%0b sum=%h acc=%h required 1 %h %h", k, out_valid, out_sum, acc_q, 16'(5 * k), 16'(5 * k));
      end
    end
    clr_acc = 1;
    tick;
    in_valid = 0; clr_acc = 0; in_use_acc = 0;
    vectors++;
    if ({out_valid, out_sum, acc_q} !== {1'b1, 16'd25, 16'd0}) begin
      miscompares++;
      $display("FAIL acc_clr_coincident: valid=%0b sum=%h acc=%h required 1 0019 0000", out_valid, out_sum, acc_q);
    end
    tick;
    m_acc = 0;
    m_c   = 0;
  endtask

  task automatic test_random;
    logic acc_ok, pop, push;
    logic [19:0] e;
    q.delete();
    for (int k = 0; k < 400; k++) begin
      vectors++;
      if ({out_valid, in_ready} !== {q.size() > 0, q.size() < 2}) begin
        miscompares++;
        $display("FAIL rand_hs_%0d: valid=%0b ready=%0b required %0b %0b", k, out_valid, in_ready, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        vectors++;
        if ({out_sum, out_c, out_v, out_z, out_n} !== q[0]) begin
          miscompares++;
          $display("FAIL rand_head_%0d: sum=%h cvzn=%b%b%b%b required %h %b", k, out_sum, out_c, out_v, out_z, out_n, q[0][19:4], q[0][3:0]);
        end
      end
      vectors++;
      acc_ok = acc_q === m_acc;
      if (!acc_ok) begin
        miscompares++;
        $display("FAIL rand_acc_%0d: acc=%h required %h", k, acc_q, m_acc);
      end
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      in_op      = 2'($urandom_range(0, 3));
      in_use_acc = $urandom_range(0, 1) == 1;
      clr_acc    = ($urandom_range(0, 15) == 0);
      in_a       = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
      in_b       = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      push = in_valid && (q.size() < 2);
      pop  = (q.size() > 0) && out_ready;
      e = model(in_op, in_use_acc ? m_acc : in_a, in_b, m_c);
      tick;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
      if (clr_acc) begin
        m_acc = 0;
        m_c   = 0;
      end else if (push) begin
        m_acc = e[19:4];
        m_c   = e[3];
      end
    end
    in_valid = 0; clr_acc = 0; out_ready = 1;
    tick;
    tick;
    q.delete();
  endtask

  task automatic test_reset_mid;
    out_ready = 0; in_use_acc = 0; in_op = 2'd0; in_a = 7; in_b = 8; in_valid = 1;
    tick;
    tick;
    in_valid = 0;
    vectors++;
    if ({out_valid, in_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL rstmid_full: valid=%0b ready=%0b required 1 0", out_valid, in_ready);
    end
    #2 rst_n = 0;
    #1;
    vectors++;
    if ({out_valid, acc_q, in_ready} !== {1'b0, 16'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL rstmid_async: valid=%0b acc=%h ready=%0b required 0 0000 1", out_valid, acc_q, in_ready);
    end
    @(negedge clk);
    rst_n = 1;
    tick;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL rstmid_release: valid=%0b ready=%0b required 0 1", out_valid, in_ready);
    end
    m_acc = 0;
    m_c   = 0;
  endtask

  initial begin
    tick;
    tick;
    test_reset;
    @(negedge clk);
    rst_n = 1;
    tick;
    test_reset;
    test_flags;
    test_back_to_back;
    test_accumulate;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
